// File: rtl/telemetry_byte_serializer.sv
// Buffers 88-bit telemetry records in a small FIFO and streams each one out as
// a 13-byte frame: sync byte, 11 payload bytes MSB first, XOR checksum.
module telemetry_byte_serializer #(
    parameter int          G_DEPTH     = 4,
    parameter logic [7:0]  G_SYNC_BYTE = 8'hA5
) (
    input  logic                        clk_256M,
    input  logic                        rst_256M_n,
    input  logic [87:0]                 data_in,
    input  logic                        valid_in,
    output logic [7:0]                  byte_out,
    output logic                        byte_valid_out,
    input  logic                        byte_ready_in,
    output logic [$clog2(G_DEPTH):0]    fifo_level_out,
    output logic [15:0]                 drop_cnt_out,
    output logic                        overflow_out
);

    localparam int AW = $clog2(G_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(G_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_SYNC, S_PAYLOAD, S_CSUM} state_t;

    function automatic logic [7:0] xor_bytes(input logic [87:0] d);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < 11; i++) x ^= d[i*8 +: 8];
        return x;
    endfunction

    // Reset asserts asynchronously but releases on a clock edge.
    logic rst_sync_q;
    always_ff @(posedge clk_256M or negedge rst_256M_n) begin
        if (!rst_256M_n) rst_sync_q <= 1'b0;
        else             rst_sync_q <= 1'b1;
    end

    logic [87:0]    mem_q [G_DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]  level_q, level_d;
    logic [15:0]    drop_cnt_q, drop_cnt_d;
    logic           overflow_q, overflow_d;
    logic           push, pop, drop;

    state_t         state_q, state_d;
    logic [3:0]     idx_q, idx_d;
    logic [87:0]    shift_q, shift_d;
    logic [7:0]     csum_q, csum_d;
    logic [87:0]    head;

    assign head = mem_q[rd_ptr_q];

    // Framing FSM; outputs decode straight from registered state so they hold under backpressure.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        shift_d        = shift_q;
        csum_d         = csum_q;
        pop            = 1'b0;
        byte_valid_out = 1'b0;
        byte_out       = 8'h00;
        case (state_q)
            S_IDLE: begin
                if (level_q != '0) begin
                    pop     = 1'b1;
                    shift_d = head;
                    csum_d  = xor_bytes(head);
                    state_d = S_SYNC;
                end
            end
            S_SYNC: begin
                byte_valid_out = 1'b1;
                byte_out       = G_SYNC_BYTE;
                if (byte_ready_in) begin
                    state_d = S_PAYLOAD;
                    idx_d   = 4'd0;
                end
            end
            S_PAYLOAD: begin
                byte_valid_out = 1'b1;
                byte_out       = shift_q[87:80];
                if (byte_ready_in) begin
                    shift_d = {shift_q[79:0], 8'h00};
                    idx_d   = idx_q + 4'd1;
                    if (idx_q == 4'd10) state_d = S_CSUM;
                end
            end
            S_CSUM: begin
                byte_valid_out = 1'b1;
                byte_out       = csum_q;
                if (byte_ready_in) begin
                    if (level_q != '0) begin
                        pop     = 1'b1;
                        shift_d = head;
                        csum_d  = xor_bytes(head);
                        state_d = S_SYNC;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A full FIFO still takes a push when the head leaves on the same edge.
    always_comb begin
        push       = valid_in && ((level_q != FULL_LVL) || pop);
        drop       = valid_in && !push;
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d    = level_q;
        if (push && !pop)      level_d = level_q + LW'(1);
        else if (!push && pop) level_d = level_q - LW'(1);
        drop_cnt_d = (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
        overflow_d = overflow_q | drop;
    end

    always_ff @(posedge clk_256M) begin
        if (push) mem_q[wr_ptr_q] <= data_in;
    end

    always_ff @(posedge clk_256M or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q    <= S_IDLE;
            idx_q      <= 4'd0;
            shift_q    <= '0;
            csum_q     <= 8'h00;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            drop_cnt_q <= 16'h0000;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            csum_q     <= csum_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    assign fifo_level_out = level_q;
    assign drop_cnt_out   = drop_cnt_q;
    assign overflow_out   = overflow_q;

endmodule

// File: tb/tb_telemetry_byte_serializer.sv
// Directed bench for telemetry_byte_serializer: frame content, latency,
// backpressure, overflow, full push/pop, drop saturation and mid-frame reset.
module tb_telemetry_byte_serializer;

    logic        clk_256M;
    logic        rst_256M_n;
    logic [87:0] data_in;
    logic        valid_in;
    logic [7:0]  byte_out;
    logic        byte_valid_out;
    logic        byte_ready_in;
    logic [2:0]  fifo_level_out;
    logic [15:0] drop_cnt_out;
    logic        overflow_out;

    telemetry_byte_serializer #(.G_DEPTH(4), .G_SYNC_BYTE(8'hA5)) dut (
        .clk_256M       (clk_256M),
        .rst_256M_n     (rst_256M_n),
        .data_in        (data_in),
        .valid_in       (valid_in),
        .byte_out       (byte_out),
        .byte_valid_out (byte_valid_out),
        .byte_ready_in  (byte_ready_in),
        .fifo_level_out (fifo_level_out),
        .drop_cnt_out   (drop_cnt_out),
        .overflow_out   (overflow_out)
    );

    initial begin
        clk_256M = 1'b0;
        forever #5 clk_256M = ~clk_256M;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Records: {hdr, 72'h0, tail}; checksum hdr^tail worked out by hand.
    logic [7:0] hdr_tab  [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    logic [7:0] tail_tab [6] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    logic [7:0] csum_tab [6] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};

    function automatic logic [87:0] rec(input int k);
        return {hdr_tab[k], 72'h0, tail_tab[k]};
    endfunction

    // Transfers are captured at the falling edge, ahead of the rising edge that commits them.
    logic [7:0] got_q [$];
    bit         prev_hold = 1'b0;
    logic [7:0] prev_byte = 8'h00;

    always @(negedge clk_256M) begin
        if (prev_hold && rst_256M_n) begin
            chk("hold_valid", {31'd0, byte_valid_out}, 32'd1);
            chk("hold_byte", {24'd0, byte_out}, {24'd0, prev_byte});
        end
        prev_hold = rst_256M_n && byte_valid_out && !byte_ready_in;
        prev_byte = byte_out;
        if (rst_256M_n && byte_valid_out && byte_ready_in) got_q.push_back(byte_out);
    end

    task automatic tick;
        @(posedge clk_256M);
        #1;
    endtask

    task automatic push_rec(input logic [87:0] d);
        data_in  = d;
        valid_in = 1'b1;
        tick;
        valid_in = 1'b0;
        data_in  = '0;
    endtask

    task automatic do_reset;
        rst_256M_n    = 1'b0;
        valid_in      = 1'b0;
        byte_ready_in = 1'b0;
        #1;
        chk("rst_valid", {31'd0, byte_valid_out}, 32'd0);
        chk("rst_byte", {24'd0, byte_out}, 32'd0);
        chk("rst_level", {29'd0, fifo_level_out}, 32'd0);
        chk("rst_drop", {16'd0, drop_cnt_out}, 32'd0);
        chk("rst_ovf", {31'd0, overflow_out}, 32'd0);
        tick;
        tick;
        rst_256M_n = 1'b1;
        tick;
        tick;
        got_q.delete();
    endtask

    task automatic wait_bytes(input int n, input int budget, input bit rnd);
        int cyc = 0;
        while (got_q.size() < n && cyc < budget) begin
            if (rnd) byte_ready_in = 1'($urandom_range(0, 1));
            tick;
            cyc++;
        end
        chk("wait_bytes", got_q.size(), n);
    endtask

    task automatic check_frame(input string tag, input int off,
                               input logic [7:0] h, input logic [7:0] t, input logic [7:0] c);
        logic [7:0] exp;
        logic [7:0] b;
        for (int j = 0; j < 13; j++) begin
            if (j == 0)       exp = 8'hA5;
            else if (j == 1)  exp = h;
            else if (j == 11) exp = t;
            else if (j == 12) exp = c;
            else              exp = 8'h00;
            b = (off + j < got_q.size()) ? got_q[off + j] : 8'hxx;
            chk($sformatf("%s_b%0d", tag, j), {24'd0, b}, {24'd0, exp});
        end
    endtask

    initial begin
        rst_256M_n    = 1'b0;
        valid_in      = 1'b0;
        data_in       = '0;
        byte_ready_in = 1'b0;
        tick;
        do_reset;

        // Single record, ready held high: latency N+2 and 13 back-to-back bytes.
        byte_ready_in = 1'b1;
        push_rec(88'h0E_0000_0000_0000_0000_0001);
        @(negedge clk_256M);
        chk("lat_n1_valid", {31'd0, byte_valid_out}, 32'd0);
        tick;
        @(negedge clk_256M);
        chk("lat_n2_valid", {31'd0, byte_valid_out}, 32'd1);
        chk("lat_n2_byte", {24'd0, byte_out}, 32'hA5);
        repeat (13) tick;
        chk("t1_count", got_q.size(), 13);
        chk("t1_idle", {31'd0, byte_valid_out}, 32'd0);
        check_frame("t1", 0, 8'h0E, 8'h01, 8'h0F);

        // Same record under random backpressure.
        got_q.delete();
        push_rec(88'h0E_0000_0000_0000_0000_0001);
        wait_bytes(13, 400, 1'b1);
        byte_ready_in = 1'b1;
        repeat (4) tick;
        chk("t2_count", got_q.size(), 13);
        check_frame("t2", 0, 8'h0E, 8'h01, 8'h0F);

        // Overflow: six pushes with the sink stalled.
        do_reset;
        for (int k = 0; k < 6; k++) push_rec(rec(k));
        chk("ovf_level", {29'd0, fifo_level_out}, 32'd4);
        chk("ovf_drop", {16'd0, drop_cnt_out}, 32'd1);
        chk("ovf_flag", {31'd0, overflow_out}, 32'd1);
        chk("ovf_sync", {24'd0, byte_out}, 32'hA5);
        byte_ready_in = 1'b1;
        wait_bytes(65, 200, 1'b0);
        repeat (5) tick;
        chk("ovf_count", got_q.size(), 65);
        chk("ovf_level_end", {29'd0, fifo_level_out}, 32'd0);
        chk("ovf_sticky", {31'd0, overflow_out}, 32'd1);
        for (int k = 0; k < 5; k++)
            check_frame($sformatf("ovf_f%0d", k), k * 13, hdr_tab[k], tail_tab[k], csum_tab[k]);

        // Push while full on the cycle the checksum byte transfers.
        do_reset;
        for (int k = 0; k < 5; k++) push_rec(rec(k));
        chk("full_level", {29'd0, fifo_level_out}, 32'd4);
        byte_ready_in = 1'b1;
        repeat (12) tick;
        chk("full_csum_pres", {24'd0, byte_out}, 32'h10);
        push_rec(rec(5));
        chk("full_drop", {16'd0, drop_cnt_out}, 32'd0);
        chk("full_level_kept", {29'd0, fifo_level_out}, 32'd4);
        chk("full_ovf", {31'd0, overflow_out}, 32'd0);
        wait_bytes(78, 300, 1'b0);
        for (int k = 0; k < 6; k++)
            check_frame($sformatf("full_f%0d", k), k * 13, hdr_tab[k], tail_tab[k], csum_tab[k]);

        // Drop counter saturation: 5 accepted, then 65537 drops.
        do_reset;
        data_in  = rec(0);
        valid_in = 1'b1;
        repeat (65539) tick;
        chk("sat_fffe", {16'd0, drop_cnt_out}, 32'h0000FFFE);
        chk("sat_level", {29'd0, fifo_level_out}, 32'd4);
        repeat (3) tick;
        chk("sat_ffff", {16'd0, drop_cnt_out}, 32'h0000FFFF);
        repeat (2) tick;
        valid_in = 1'b0;
        chk("sat_hold", {16'd0, drop_cnt_out}, 32'h0000FFFF);
        chk("sat_ovf", {31'd0, overflow_out}, 32'd1);

        // Reset in the middle of a frame at payload index 5 with two records queued.
        do_reset;
        byte_ready_in = 1'b1;
        data_in = rec(0); valid_in = 1'b1; tick;
        data_in = rec(1); tick;
        data_in = rec(2); tick;
        valid_in = 1'b0;
        data_in  = '0;
        repeat (5) tick;
        chk("mid_count", got_q.size(), 6);
        chk("mid_level", {29'd0, fifo_level_out}, 32'd2);
        chk("mid_byte_idx5", {24'd0, byte_out}, 32'h00);
        rst_256M_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, byte_valid_out}, 32'd0);
        chk("mid_rst_level", {29'd0, fifo_level_out}, 32'd0);
        tick;
        tick;
        rst_256M_n = 1'b1;
        repeat (40) tick;
        chk("mid_after_count", got_q.size(), 6);
        chk("mid_after_valid", {31'd0, byte_valid_out}, 32'd0);
        chk("mid_after_level", {29'd0, fifo_level_out}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/telemetry_byte_serializer.md
TELEMETRY_BYTE_SERIALIZER -- requirements
Module: telemetry_byte_serializer

Interface
REQ-001 The block SHALL have parameter G_DEPTH, default 4, giving the record FIFO depth in 88-bit records (power of 2, 2..16).
REQ-002 The block SHALL have parameter G_SYNC_BYTE, default 8'hA5, giving the frame start byte.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 The block SHALL have port clk_256M, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst_256M_n, input, 1 bit: the asynchronous active-low reset.
REQ-006 The block SHALL have port data_in, input, 88 bits: the unpacked telemetry record from the GT unpack stage.
REQ-007 The block SHALL have port valid_in, input, 1 bit: a single-cycle strobe qualifying data_in, with no backpressure.
REQ-008 The block SHALL have port byte_out, output, 8 bits: the serialized frame byte.
REQ-009 The block SHALL have port byte_valid_out, output, 1 bit: qualifies byte_out.
REQ-010 The block SHALL have port byte_ready_in, input, 1 bit: sink ready; a byte transfers when byte_valid_out and byte_ready_in are both 1.
REQ-011 The block SHALL have port fifo_level_out, output, clog2(G_DEPTH)+1 bits: the number of records stored.
REQ-012 The block SHALL have port drop_cnt_out, output, 16 bits: the number of records dropped.
REQ-013 The block SHALL have port overflow_out, output, 1 bit: a sticky flag indicating that at least one record was dropped.

Function
REQ-014 The block SHALL emit a 13-byte frame per record in this order: G_SYNC_BYTE; data[87:80], data[79:72], ..., data[7:0]; checksum.
REQ-015 The checksum SHALL be the bitwise XOR of the 11 payload bytes; the sync byte is excluded.
REQ-016 The FIFO SHALL accept a push when valid_in=1 and the level is < G_DEPTH.
REQ-017 When the level equals G_DEPTH and a pop occurs in the same cycle, the FIFO SHALL also accept the push; the level stays unchanged.
REQ-018 When valid_in=1 and the record cannot be accepted, the block SHALL discard it, increment drop_cnt_out (saturating at 16'hFFFF), and set overflow_out.
REQ-019 The FSM SHALL have states IDLE, SYNC, PAYLOAD and CSUM, plus an internal 4-bit byte index 0..10.
REQ-020 IDLE: when the FIFO is non-empty, the FSM SHALL pop the head record into an 88-bit shift register, latch its checksum, and go to SYNC. byte_valid_out=0 in IDLE.
REQ-021 SYNC: byte_out=G_SYNC_BYTE and byte_valid_out=1; on transfer, the FSM SHALL go to PAYLOAD with index=0.
REQ-022 PAYLOAD: byte_out=shift[87:80]; on transfer, the FSM SHALL shift left by 8 and increment the index. On the transfer at index 10 it SHALL go to CSUM.
REQ-023 CSUM: byte_out=checksum; on transfer, if the FIFO is non-empty, the FSM SHALL pop and load the next record and go to SYNC in the same edge (no idle bubble); otherwise it SHALL go to IDLE.
REQ-024 While byte_valid_out=1 and byte_ready_in=0, byte_out and the state SHALL hold stable.
REQ-025 byte_valid_out SHALL NOT deassert until a transfer occurs.
REQ-026 Latency: for valid_in at cycle N, with an empty FIFO and the FSM in IDLE, the sync byte SHALL be presented with byte_valid_out=1 at cycle N+2.
REQ-027 With byte_ready_in held at 1, consecutive frames SHALL be back-to-back: 13 cycles per frame.
REQ-028 fifo_level_out SHALL update on the edge after a push or pop.
REQ-029 When a push and a pop occur in the same cycle, the level SHALL be unchanged.
REQ-030 FIFO read and write pointers SHALL wrap modulo G_DEPTH.
REQ-031 byte_ready_in SHALL be ignored while byte_valid_out=0.

Reset
REQ-032 On assertion of rst_256M_n=0, asynchronously: FSM=IDLE, FIFO pointers and level=0, byte_out=8'h00, byte_valid_out=0, drop_cnt_out=0, overflow_out=0, shift register and checksum=0.
REQ-033 Reset mid-frame SHALL abort the frame with no further bytes emitted and SHALL discard all queued records.
REQ-034 Deassertion of reset SHALL be synchronous to clk_256M; the first push is accepted on the second edge after deassertion.

Verification
REQ-035 Single record: push data_in=88'h0E_0000_0000_0000_0000_0001 with ready=1 -> bytes A5,0E,00x9,01,0F on 13 consecutive cycles, first at N+2.
REQ-036 Backpressure: toggle byte_ready_in randomly -> byte stream identical to REQ-035; byte_out stable whenever valid=1 and ready=0.
REQ-037 Overflow: ready=0 and push 6 records with G_DEPTH=4 -> fifo_level_out=4, drop_cnt_out=1, overflow_out=1 (one record is held in the shift register), and the first 5 records are emitted in order when ready=1.
REQ-038 Simultaneous push and pop at full: push on the cycle the CSUM byte transfers -> record accepted, drop_cnt_out unchanged, level stays 4.
REQ-039 Drop counter saturation: force 65 537 drops -> drop_cnt_out=16'hFFFF.
REQ-040 Reset mid-PAYLOAD at index 5 with 2 records queued -> byte_valid_out=0 immediately, level=0, and no bytes emitted after reset until a new push.
